// File: rtl/port_uart_pkg.sv
// port_uart_pkg
// Shared types and bit positions for the port_uart_tx serial transmit stage.
//   tx_state_t   : transmitter FSM states
//   ST_*         : bit positions inside the 32-bit port_in status word
//   PO_*         : bit positions inside the 32-bit port_out command word
package port_uart_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } tx_state_t;

   localparam int ST_ACK       = 0;
   localparam int ST_FULL      = 1;
   localparam int ST_EMPTY     = 2;
   localparam int ST_BUSY      = 3;
   localparam int ST_COUNT_LSB = 4;

   localparam int PO_REQ      = 8;
   localparam int PO_DATA_MSB = 7;

endpackage

// File: rtl/port_uart_tx_fifo.sv
// byte_fifo
// Small byte FIFO with power-of-two depth and a combinational head output.
//   clk, rst     : clock, asynchronous active-low reset
//   push, din    : write din when not full
//   pop, dout    : dout always shows the head entry; pop discards it when not empty
//   full, empty  : occupancy flags derived from the registered count
//   count        : number of stored bytes (0..FIFO_DEPTH)
module byte_fifo #(
   parameter int FIFO_DEPTH = 4
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          push,
   input  logic                          pop,
   input  logic [7:0]                    din,
   output logic [7:0]                    dout,
   output logic                          full,
   output logic                          empty,
   output logic [$clog2(FIFO_DEPTH):0]   count
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;

   logic [7:0]    mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          push_ok;
   logic          pop_ok;

   assign full    = (count == CW'(FIFO_DEPTH));
   assign empty   = (count == '0);
   assign push_ok = push && !full;
   assign pop_ok  = pop && !empty;
   assign dout    = mem[rd_ptr];

   // Pointers wrap naturally because the depth is a power of two.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + 1'b1;
         if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
         if (push_ok && !pop_ok)      count <= count + 1'b1;
         else if (pop_ok && !push_ok) count <= count - 1'b1;
      end
   end

   // Storage needs no reset: the cleared pointers make old contents unreachable.
   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/port_uart_tx.sv
// port_uart_tx
// Serial 8N1 transmitter fed by the CPU core's output port through a toggle
// request/acknowledge handshake, with a byte FIFO in between.
//   clk       : system clock shared with the core
//   rst       : asynchronous active-low reset
//   port_out  : [7:0] data byte, [8] request toggle, rest ignored
//   port_in   : [0] ack toggle, [1] full, [2] empty, [3] busy, [7:4] count, rest zero
//   txd       : registered serial output, idle high
module port_uart_tx
   import port_uart_pkg::*;
#(
   parameter int CLK_DIV    = 16,
   parameter int FIFO_DEPTH = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] port_out,
   output logic [31:0] port_in,
   output logic        txd
);

   localparam int          CW          = $clog2(FIFO_DEPTH) + 1;
   localparam logic [15:0] BAUD_RELOAD = 16'(CLK_DIV - 1);

   logic          armed;
   logic          req_prev;
   logic          ack;
   logic          req_bit;
   logic          push;
   logic          pop;
   logic          full;
   logic          empty;
   logic [7:0]    fifo_dout;
   logic [CW-1:0] fifo_count;
   logic [3:0]    count_field;
   logic          unused_port_bits;

   tx_state_t     state;
   tx_state_t     state_next;
   logic [15:0]   baud_cnt;
   logic [15:0]   baud_next;
   logic [2:0]    bit_idx;
   logic [2:0]    bit_next;
   logic [7:0]    shift_q;
   logic [7:0]    shift_next;
   logic          txd_q;
   logic          txd_next;

   assign req_bit          = port_out[PO_REQ];
   assign unused_port_bits = ^port_out[31:9];

   // Full is the registered flag, so a pop on the same edge never frees a slot early.
   assign push = armed && (req_bit != req_prev) && !full;

   byte_fifo #(
      .FIFO_DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .pop   (pop),
      .din   (port_out[PO_DATA_MSB:0]),
      .dout  (fifo_dout),
      .full  (full),
      .empty (empty),
      .count (fifo_count)
   );

   // The first edge after reset adopts whatever request level the core's port
   // register already holds, so a stale toggle is never taken as a new byte.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         armed    <= 1'b0;
         req_prev <= 1'b0;
         ack      <= 1'b0;
      end else if (!armed) begin
         armed    <= 1'b1;
         req_prev <= req_bit;
         ack      <= req_bit;
      end else if (push) begin
         req_prev <= req_bit;
         ack      <= req_bit;
      end
   end

   // Transmitter state register; txd is registered so it cannot glitch.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= IDLE;
         baud_cnt <= '0;
         bit_idx  <= '0;
         shift_q  <= '0;
         txd_q    <= 1'b1;
      end else begin
         state    <= state_next;
         baud_cnt <= baud_next;
         bit_idx  <= bit_next;
         shift_q  <= shift_next;
         txd_q    <= txd_next;
      end
   end

   // Next-state logic. txd_next is the level for the cycle after this edge, so
   // each transition also selects the first bit of the state being entered.
   always_comb begin
      state_next = state;
      baud_next  = baud_cnt;
      bit_next   = bit_idx;
      shift_next = shift_q;
      txd_next   = txd_q;
      pop        = 1'b0;
      case (state)
         IDLE: begin
            txd_next = 1'b1;
            if (!empty) begin
               pop        = 1'b1;
               shift_next = fifo_dout;
               bit_next   = '0;
               baud_next  = BAUD_RELOAD;
               txd_next   = 1'b0;
               state_next = START;
            end
         end
         START: begin
            if (baud_cnt == '0) begin
               baud_next  = BAUD_RELOAD;
               txd_next   = shift_q[0];
               state_next = DATA;
            end else begin
               baud_next = baud_cnt - 1'b1;
            end
         end
         DATA: begin
            if (baud_cnt == '0) begin
               baud_next = BAUD_RELOAD;
               if (bit_idx == 3'd7) begin
                  txd_next   = 1'b1;
                  state_next = STOP;
               end else begin
                  shift_next = shift_q >> 1;
                  bit_next   = bit_idx + 1'b1;
                  txd_next   = shift_q[1];
               end
            end else begin
               baud_next = baud_cnt - 1'b1;
            end
         end
         STOP: begin
            if (baud_cnt == '0) begin
               // A waiting byte starts immediately so frames run back-to-back.
               if (!empty) begin
                  pop        = 1'b1;
                  shift_next = fifo_dout;
                  bit_next   = '0;
                  baud_next  = BAUD_RELOAD;
                  txd_next   = 1'b0;
                  state_next = START;
               end else begin
                  txd_next   = 1'b1;
                  state_next = IDLE;
               end
            end else begin
               baud_next = baud_cnt - 1'b1;
            end
         end
         default: begin
            txd_next   = 1'b1;
            state_next = IDLE;
         end
      endcase
   end

   assign txd = txd_q;

   // A full 16-entry FIFO truncates to 0 here; software uses the full flag instead.
   assign count_field = 4'(fifo_count);

   // Status is built from registered state only, never from port_out.
   always_comb begin
      port_in                       = '0;
      port_in[ST_ACK]               = ack;
      port_in[ST_FULL]              = full;
      port_in[ST_EMPTY]             = empty;
      port_in[ST_BUSY]              = (state != IDLE);
      port_in[ST_COUNT_LSB +: 4]    = count_field;
   end

endmodule

// File: tb/tb_port_uart_tx.sv
// tb_port_uart_tx
// Self-checking bench for port_uart_tx with CLK_DIV=4 and FIFO_DEPTH=4.
// Handshake cycles come from a vector table; a serial receiver process decodes
// txd into frames that are compared against the bytes pushed.
module tb_port_uart_tx;

   localparam int CLK_DIV    = 4;
   localparam int FIFO_DEPTH = 4;
   localparam int FRAME      = 10 * CLK_DIV;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [31:0] port_out = '0;
   logic [31:0] port_in;
   logic        txd;

   int checks = 0;
   int passes = 0;
   int cycle_cnt = 0;

   typedef struct {
      int          group;
      logic [31:0] port_out;
      logic [31:0] exp_port_in;
      logic        exp_txd;
      string       name;
   } vec_t;

   typedef struct {
      logic [7:0] data;
      int         start;
      bit         err;
   } frame_t;

   vec_t       vecs[$];
   frame_t     mon_q[$];
   logic [7:0] exp_q[$];

   port_uart_tx #(
      .CLK_DIV    (CLK_DIV),
      .FIFO_DEPTH (FIFO_DEPTH)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .port_out (port_out),
      .port_in  (port_in),
      .txd      (txd)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual === expected) passes++;
      else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
   endtask

   task automatic applyStimulus(input logic [31:0] po);
      port_out = po;
      step();
   endtask

   task automatic addVec(input int g, input logic [31:0] po, input logic [31:0] pi, input logic t, input string n);
      vec_t v;
      v.group       = g;
      v.port_out    = po;
      v.exp_port_in = pi;
      v.exp_txd     = t;
      v.name        = n;
      vecs.push_back(v);
   endtask

   task automatic runVectors(input int g);
      foreach (vecs[i]) begin
         if (vecs[i].group == g) begin
            applyStimulus(vecs[i].port_out);
            checkOutput({vecs[i].name, "_port_in"}, port_in, vecs[i].exp_port_in);
            checkOutput({vecs[i].name, "_txd"}, {31'b0, txd}, {31'b0, vecs[i].exp_txd});
         end
      end
   endtask

   task automatic waitIdle(input string name, input logic [31:0] idle_word, input int limit);
      int n;
      n = 0;
      while (port_in !== idle_word && n < limit) begin
         step();
         n++;
      end
      checkOutput(name, port_in, idle_word);
   endtask

   task automatic checkFrames(input string name);
      checkOutput({name, "_frame_count"}, 32'(mon_q.size()), 32'(exp_q.size()));
      for (int i = 0; i < mon_q.size() && i < exp_q.size(); i++) begin
         checkOutput($sformatf("%s_byte%0d", name, i), {24'b0, mon_q[i].data}, {24'b0, exp_q[i]});
         checkOutput($sformatf("%s_framing%0d", name, i), {31'b0, mon_q[i].err}, 32'd0);
         if (i > 0)
            checkOutput($sformatf("%s_spacing%0d", name, i), 32'(mon_q[i].start - mon_q[i-1].start), 32'(FRAME));
      end
      mon_q.delete();
      exp_q.delete();
   endtask

   // Serial receiver: records every full frame, checks each bit cell is steady,
   // and drops any frame cut short by reset.
   initial begin : monitor
      logic   samples [FRAME];
      logic   mid;
      bit     aborted;
      frame_t f;
      forever begin
         step();
         if (rst === 1'b1 && txd === 1'b0) begin
            f.start    = cycle_cnt;
            f.err      = 1'b0;
            f.data     = '0;
            aborted    = 1'b0;
            samples[0] = txd;
            for (int i = 1; i < FRAME; i++) begin
               step();
               if (rst !== 1'b1) begin
                  aborted = 1'b1;
                  break;
               end
               samples[i] = txd;
            end
            if (!aborted) begin
               for (int c = 0; c < 10; c++) begin
                  mid = samples[c*CLK_DIV + CLK_DIV/2];
                  for (int k = 0; k < CLK_DIV; k++)
                     if (samples[c*CLK_DIV + k] !== mid) f.err = 1'b1;
                  if (c == 0 && mid !== 1'b0) f.err = 1'b1;
                  if (c == 9 && mid !== 1'b1) f.err = 1'b1;
                  if (c >= 1 && c <= 8) f.data[c-1] = mid;
               end
               mon_q.push_back(f);
            end
         end
      end
   end

   initial begin : main
      int bad;
      int s_cyc;
      int n;

      // group 0: single byte 0x55; ack, count and start-bit timing
      addVec(0, 32'h155, 32'h11, 1'b1, "single_push");
      addVec(0, 32'h155, 32'h0D, 1'b0, "single_start0");
      addVec(0, 32'h155, 32'h0D, 1'b0, "single_start1");
      addVec(0, 32'h155, 32'h0D, 1'b0, "single_start2");
      addVec(0, 32'h155, 32'h0D, 1'b0, "single_start3");
      addVec(0, 32'h155, 32'h0D, 1'b1, "single_bit0");
      // group 1: priming byte 0x99 then A0..A4 while it is in flight
      addVec(1, 32'h099, 32'h10, 1'b1, "bp_prime");
      addVec(1, 32'h099, 32'h0C, 1'b0, "bp_prime_start");
      addVec(1, 32'h1A0, 32'h19, 1'b0, "bp_a0");
      addVec(1, 32'h0A1, 32'h28, 1'b0, "bp_a1");
      addVec(1, 32'h1A2, 32'h39, 1'b0, "bp_a2");
      addVec(1, 32'h0A3, 32'h4A, 1'b1, "bp_a3_full");
      addVec(1, 32'h1A4, 32'h4A, 1'b1, "bp_a4_held0");
      addVec(1, 32'h1A4, 32'h4A, 1'b1, "bp_a4_held1");
      // group 2: push/pop overlap at IDLE, then fill to two
      addVec(2, 32'h0B0, 32'h10, 1'b1, "simul_b0");
      addVec(2, 32'h1B1, 32'h19, 1'b0, "simul_b1");
      addVec(2, 32'h0B2, 32'h28, 1'b0, "simul_b2");
      // group 3: byte 0xD2 later interrupted by reset
      addVec(3, 32'h0D2, 32'h10, 1'b1, "midrst_push");
      addVec(3, 32'h0D2, 32'h0C, 1'b0, "midrst_start");
      // group 4: first push after the stale-request re-arm
      addVec(4, 32'h03C, 32'h10, 1'b1, "rearm_push");

      $display("[TB] reset");
      repeat (3) step();
      checkOutput("reset_port_in", port_in, 32'h4);
      checkOutput("reset_txd", {31'b0, txd}, 32'd1);
      rst = 1'b1;
      step();
      bad = 0;
      for (int i = 0; i < 100; i++) begin
         if (port_in !== 32'h4 || txd !== 1'b1) bad++;
         step();
      end
      checkOutput("idle_quiet_cycles", bad, 0);
      checkOutput("idle_no_frame", 32'(mon_q.size()), 32'd0);

      $display("[TB] single byte");
      runVectors(0);
      bad = 0;
      for (int i = 0; i < 35; i++) begin
         step();
         if (port_in !== 32'h0D) bad++;
      end
      checkOutput("single_busy_held", bad, 0);
      checkOutput("single_stop_txd", {31'b0, txd}, 32'd1);
      step();
      checkOutput("single_busy_clear", port_in, 32'h5);
      exp_q.push_back(8'h55);
      checkFrames("single");

      $display("[TB] backpressure");
      runVectors(1);
      s_cyc = cycle_cnt - 6;
      n = 0;
      while (port_in[1] === 1'b1 && n < 100) begin
         step();
         n++;
      end
      checkOutput("bp_slot_free_cycle", 32'(cycle_cnt - s_cyc), 32'(FRAME));
      checkOutput("bp_ack_withheld", port_in, 32'h38);
      step();
      checkOutput("bp_late_accept", port_in, 32'h4B);
      waitIdle("bp_drain", 32'h5, 300);
      exp_q.push_back(8'h99);
      for (int i = 0; i < 5; i++) exp_q.push_back(8'hA0 + 8'(i));
      checkFrames("bp");

      $display("[TB] simultaneous push and pop");
      runVectors(2);
      s_cyc = cycle_cnt - 1;
      while (cycle_cnt < s_cyc + FRAME - 1) step();
      checkOutput("simul_before_pop", port_in, 32'h28);
      applyStimulus(32'h1B3);
      checkOutput("simul_count_held", port_in, 32'h29);
      waitIdle("simul_drain", 32'h5, 300);
      exp_q.push_back(8'hB0);
      exp_q.push_back(8'hB1);
      exp_q.push_back(8'hB2);
      exp_q.push_back(8'hB3);
      checkFrames("simul");

      $display("[TB] reset mid-frame");
      runVectors(3);
      s_cyc = cycle_cnt;
      while (cycle_cnt < s_cyc + 17) step();
      checkOutput("midrst_bit3_txd", {31'b0, txd}, 32'd0);
      checkOutput("midrst_busy_word", port_in, 32'h0C);
      rst = 1'b0;
      #1;
      checkOutput("midrst_txd", {31'b0, txd}, 32'd1);
      checkOutput("midrst_port_in", port_in, 32'h4);

      $display("[TB] stale request");
      port_out = 32'h1C7;
      step();
      step();
      rst = 1'b1;
      step();
      checkOutput("stale_ack", port_in, 32'h5);
      bad = 0;
      for (int i = 0; i < 50; i++) begin
         step();
         if (port_in !== 32'h5 || txd !== 1'b1) bad++;
      end
      checkOutput("stale_no_push", bad, 0);
      checkOutput("stale_no_frame", 32'(mon_q.size()), 32'd0);
      runVectors(4);
      waitIdle("rearm_drain", 32'h4, 200);
      exp_q.push_back(8'h3C);
      checkFrames("rearm");

      $display("[TB] %0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule

// File: doc/port_uart_tx.md
# port_uart_tx

Serial transmit stage downstream of the 4-bit CPU core. It consumes the core's 32-bit `port_out` word through a toggle request/acknowledge handshake and queues bytes in a small FIFO. It shifts each byte out as an 8N1 UART frame on `txd`. Status returns to the core on its 32-bit `port_in` word, so software can poll for acknowledge, full, empty and busy.

## Interface
- `CLK_DIV`, 16: clock cycles per serial bit; legal range 2..65535.
- `FIFO_DEPTH`, 4: byte FIFO depth; power of two, 2..16.

- `clk`  in  1  system clock, shared with the CPU core.
- `rst`  in  1  asynchronous, active-low reset.
- `port_out`  in  32  core output port. [7:0] data byte; [8] request toggle; [31:9] ignored.
- `port_in`  out  32  to core input port. [0] ack toggle; [1] FIFO full; [2] FIFO empty; [3] tx busy; [7:4] FIFO count; [31:8] zero.
- `txd`  out  1  UART serial output, idle high.

## Operation
- **Reset.** All state clears immediately on `rst` low.
  - `req_prev`, `ack` = 0, `armed` = 0.
  - FIFO empty, count 0; FSM IDLE; `txd` = 1.
  - `port_in` = 0x00000004 (empty set, all else 0).
- **Arming.** This covers the core's port registers, which may hold a stale request bit.
  - On the first clock edge after `rst` deasserts: `req_prev` ← `port_out[8]`, `ack` ← `port_out[8]`, `armed` ← 1.
  - No push occurs on that edge.
- **Push.** A push is pending when `armed` is set and `port_out[8]` != `req_prev`.
  - If the FIFO is not full, `port_out[7:0]` is written and `req_prev` and `ack` both take `port_out[8]`.
  - If the FIFO is full, nothing changes. The request stays pending and is accepted on the first edge where full is clear.
- **Full test.** The full check uses the registered count. A pop on the same edge does not free the slot for that edge's push.
- **Count rule.** Push and pop on the same edge (FIFO not full, not empty) leave the count unchanged.
- **FSM states.** IDLE, START, DATA, STOP.
  - IDLE: `txd` = 1. If the FIFO is non-empty: pop into shift register, bit index ← 0, baud counter ← CLK_DIV-1, go to START.
  - START: `txd` = 0 for CLK_DIV cycles, then go to DATA with counter reloaded.
  - DATA: `txd` = shift[0] for CLK_DIV cycles per bit, LSB first. Shift right after each bit; after bit 7, go to STOP.
  - STOP: `txd` = 1 for CLK_DIV cycles.
- **End of STOP.**
  - FIFO non-empty: pop and go straight to START, so frames are back-to-back with no idle cycle.
  - Otherwise: go to IDLE.
- **Busy.** `busy` = (state != IDLE).
- **Status decode.** `port_in` is decoded combinationally from registered state only; there is no path from `port_out` to `port_in`.
- **Count field.** The count is zero-extended to 4 bits. When FIFO_DEPTH = 16 and the FIFO is full, the field reads 0 and full = 1.

## Timing
- **Acknowledge latency.** `port_out[8]` toggles before edge E. If the push is accepted at E, `ack`, count and empty reflect it immediately after E. The core sees this on its next input-port load.
- **First start bit.** For an idle, empty block with a push at E0, IDLE pops at E0+1. `txd` falls after E0+1.
- **Frame length.** Exactly 10·CLK_DIV cycles: start bit, 8 data bits, stop bit.
- **Back-to-back frames.** The next frame's start bit follows directly after the stop bit's last cycle.
- **`txd` output.** Registered; it never glitches.
- **Reset mid-frame.** `txd` goes to 1 asynchronously, the frame is abandoned, and FIFO contents are lost. No partial frame resumes after reset.

## Structure
- **Package `port_uart_pkg`.**
  - Typedef `tx_state_t` (IDLE, START, DATA, STOP).
  - `port_in` bit-index constants: `ST_ACK`=0, `ST_FULL`=1, `ST_EMPTY`=2, `ST_BUSY`=3, `ST_COUNT_LSB`=4.
  - `port_out` constants: `PO_REQ`=8, `PO_DATA_MSB`=7.
- **Sub-module `byte_fifo`.**
  - Parameterised by FIFO_DEPTH, with async active-low `rst`.
  - Ports: push, pop, din[7:0], dout[7:0], full, empty, count.
  - dout shows the head entry combinationally.
- **Top level.** Handshake/arming logic, baud counter, bit counter, shift register, FSM.

## Test plan
- **Reset.** Hold `rst` low, release, CLK_DIV=4 → `port_in`=0x00000004, `txd`=1, no frame for 100 cycles.
- **Single byte.** `port_out`=0x155 (req 0→1, byte 0x55) → `ack`=1 one edge later; `txd` carries 0,1,0,1,0,1,0,1,0,1, each 4 cycles; busy clears after 40 cycles.
- **Backpressure.** FIFO_DEPTH=4, five rapid toggled pushes 0xA0..0xA4 while the first frame is in flight.
  - The fifth push's `ack` is withheld while full = 1.
  - It is accepted on the first edge after a pop frees a slot.
  - Five frames go out in order with no gaps.
- **Stale request.** With `port_out[8]`=1 held through reset release → no push, `ack`=1, FIFO stays empty.
- **Reset mid-frame.** Assert `rst` during DATA bit 3 → `txd`=1 that same cycle, empty=1, busy=0; after re-arm a new push transmits correctly.
- **Simultaneous push/pop.**
  - Push lands on the same edge as the end-of-STOP pop with count=2 → count stays 2.
  - Byte order is preserved.
